led_marquee: RTL and testbench
==============================

LED_MARQUEE -- requirements
Module: led_marquee

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25_000_000, clock cycles per display step (legal range 2..2^24).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port load  input  1  one-cycle strobe capturing pattern and mode.
REQ-005 SHALL have port pattern  input  24  LED pattern to display, bit 0 = led[0].
REQ-006 SHALL have port mode  input  2  00 HOLD, 01 ROT_LEFT, 10 ROT_RIGHT, 11 BLINK; sampled only on load.
REQ-007 SHALL have port en  input  1  run enable; 0 freezes prescaler and display.
REQ-008 SHALL have port led  output  24  registered LED drive, feeding the 24-bit LED bank.
REQ-009 SHALL have port step  output  1  registered one-cycle pulse on each display update.

Function
REQ-010 SHALL contain a prescaler counter, width ceil(log2(TICK_DIV)), counting 0..TICK_DIV-1 while en=1 and state RUN, then wrapping to 0.
REQ-011 SHALL generate an internal tick in the cycle the counter equals TICK_DIV-1 with en=1 and state RUN; step SHALL be asserted the following cycle, simultaneous with the led update.
REQ-012 SHALL hold counter, led and blink phase unchanged while en=0; step SHALL be 0.
REQ-013 SHALL implement states IDLE and RUN; IDLE -> RUN on load; RUN -> RUN on load; only rst returns to IDLE.
REQ-014 SHALL, in IDLE, drive led=0 and step=0 and keep counter at 0, regardless of en.
REQ-015 SHALL, on load, capture pattern into pat_reg and mode into mode_reg, set led=pattern, clear counter to 0, set blink phase ON, all visible the cycle after load; step SHALL be 0 that cycle.
REQ-016 SHALL give load priority over a coincident tick: the tick is discarded and the next step occurs TICK_DIV enabled cycles after load.
REQ-017 SHALL, on tick in HOLD, leave led unchanged but still pulse step.
REQ-018 SHALL, on tick in ROT_LEFT, set led = {led[22:0], led[23]} (bit 23 wraps to bit 0).
REQ-019 SHALL, on tick in ROT_RIGHT, set led = {led[0], led[23:1]} (bit 0 wraps to bit 23).
REQ-020 SHALL, on tick in BLINK, toggle blink phase; led = pat_reg when phase ON, 24'h000000 when OFF.
REQ-021 SHALL accept load while en=0: pattern shown immediately, stepping resumes only when en returns to 1.
REQ-022 SHALL treat patterns 24'h000000 and 24'hFFFFFF as legal; rotation leaves them unchanged and step still pulses.
REQ-023 SHALL use no combinational path from any input to led or step.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set state IDLE, counter 0, led 24'h000000, step 0, pat_reg 0, mode_reg HOLD, blink phase ON.
REQ-025 SHALL give rst priority over load, en and tick in the same cycle; reset mid-rotation SHALL clear led the next cycle.
REQ-026 SHALL ignore all inputs except clk during rst=1.

Verification (TICK_DIV=4 for all scenarios)
REQ-027 Reset: rst=1 two cycles, en=1, no load -> led=000000, step=0 for 20 cycles after release.
REQ-028 Rotate left: load pattern=800001, mode=01, en=1 -> led=800001 next cycle; after 4 cycles step=1 with led=000003; next step led=000006.
REQ-029 Rotate right wrap: load pattern=000001, mode=10 -> first step led=800000, second step led=400000.
REQ-030 Blink and pause: load pattern=A5A5A5, mode=11 -> steps alternate led=000000, A5A5A5; drop en for 10 cycles -> led and counter frozen, no step; restore en -> step after the remaining count.
REQ-031 Load/tick collision: assert load pattern=00000F, mode=01 in the tick cycle of a running ROT_LEFT -> led=00000F, step=0 next cycle; next step exactly 4 cycles later with led=00001E.
REQ-032 Reset mid-operation: rst during ROT_LEFT with led=0000F0 -> led=000000 next cycle, state IDLE; en=1 alone produces no step.

Source files
------------

// File: rtl/led_marquee.sv
// 24-LED marquee driver: a prescaler paces display steps that hold, rotate
// or blink a pattern captured on a load strobe.
module led_marquee #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] pattern,
  input  logic [1:0]  mode,
  input  logic        en,
  output logic [23:0] led,
  output logic        step
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {
    HOLD      = 2'b00,
    ROT_LEFT  = 2'b01,
    ROT_RIGHT = 2'b10,
    BLINK     = 2'b11
  } mode_t;

  state_t        state;
  mode_t         mode_reg;
  logic [CW-1:0] cnt;
  logic [23:0]   pat_reg;
  logic          phase_on;
  logic          tick;

  assign tick = (state == RUN) && en && (cnt == LAST);

  // A load always restarts the step period, so a coincident tick is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      led      <= '0;
      step     <= 1'b0;
      pat_reg  <= '0;
      mode_reg <= HOLD;
      phase_on <= 1'b1;
    end else if (load) begin
      state    <= RUN;
      pat_reg  <= pattern;
      mode_reg <= mode_t'(mode);
      led      <= pattern;
      cnt      <= '0;
      phase_on <= 1'b1;
      step     <= 1'b0;
    end else if (state == IDLE) begin
      led  <= '0;
      step <= 1'b0;
      cnt  <= '0;
    end else begin
      step <= tick;
      if (en) begin
        cnt <= tick ? '0 : cnt + CW'(1);
      end
      if (tick) begin
        case (mode_reg)
          HOLD:      led <= led;
          ROT_LEFT:  led <= {led[22:0], led[23]};
          ROT_RIGHT: led <= {led[0], led[23:1]};
          BLINK: begin
            // The displayed value follows the phase after the toggle.
            phase_on <= ~phase_on;
            led      <= phase_on ? 24'h000000 : pat_reg;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_marquee.sv
// Self-checking bench for led_marquee with TICK_DIV=4: directed scenarios and
// a randomized run, all compared against a cycle-level behavioural model.
module tb_led_marquee;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [23:0] pattern = '0;
  logic [1:0]  mode = '0;
  logic        en = 1'b0;
  logic [23:0] led;
  logic        step;

  int total = 0;
  int bad = 0;

  // Behavioural model: elapsed enabled cycles since the last step or load.
  bit          m_run;
  int          m_elapsed;
  logic [23:0] m_led;
  logic [23:0] m_pat;
  logic [1:0]  m_mode;
  bit          m_on;
  bit          m_step;

  led_marquee #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .load(load), .pattern(pattern),
    .mode(mode), .en(en), .led(led), .step(step)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rot_left(input logic [23:0] x);
    int v;
    v = int'(x);
    return 24'(((v * 2) + (v / (1 << 23))) % (1 << 24));
  endfunction

  function automatic logic [23:0] rot_right(input logic [23:0] x);
    int v;
    v = int'(x);
    return 24'((v / 2) + ((v % 2) * (1 << 23)));
  endfunction

  // One rising edge; the model consumes the same inputs the DUT sampled.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_elapsed = 0; m_led = '0; m_step = 0;
      m_pat = '0; m_mode = 2'b00; m_on = 1;
    end else if (load) begin
      m_run = 1; m_pat = pattern; m_mode = mode; m_led = pattern;
      m_elapsed = 0; m_on = 1; m_step = 0;
    end else if (!m_run) begin
      m_led = '0; m_step = 0; m_elapsed = 0;
    end else begin
      m_step = 0;
      if (en) begin
        m_elapsed++;
        if (m_elapsed == TD) begin
          m_elapsed = 0;
          m_step = 1;
          case (m_mode)
            2'b01: m_led = rot_left(m_led);
            2'b10: m_led = rot_right(m_led);
            2'b11: begin
              m_on = !m_on;
              m_led = m_on ? m_pat : 24'h000000;
            end
            default: m_led = m_led;
          endcase
        end
      end
    end
    #1;
  endtask

  task automatic do_load(input logic [23:0] p, input logic [1:0] m);
    pattern = p;
    mode = m;
    load = 1'b1;
    advance();
    load = 1'b0;
    pattern = $urandom;
    mode = 2'($urandom);
  endtask

  task automatic test_reset();
    en = 1'b1;
    rst = 1'b1;
    load = 1'b0;
    advance();
    advance();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      advance();
      total++;
      if (led !== 24'h000000 || step !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_idle cycle %0d: led=%h step=%b expected led=000000 step=0", k, led, step);
      end
    end
  endtask

  task automatic test_rotate_left();
    en = 1'b1;
    do_load(24'h800001, 2'b01);
    total++;
    if (led !== 24'h800001 || step !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rotl_load: led=%h step=%b expected led=800001 step=0", led, step);
    end
    for (int k = 1; k <= 8; k++) begin
      advance();
      total++;
      if (led !== m_led || step !== m_step) begin
        bad++;
        $display("[TB] FAIL rotl_model cycle %0d: led=%h step=%b expected led=%h step=%b", k, led, step, m_led, m_step);
      end
      if (k == 4 || k == 8) begin
        total++;
        if (step !== 1'b1 || led !== ((k == 4) ? 24'h000003 : 24'h000006)) begin
          bad++;
          $display("[TB] FAIL rotl_step cycle %0d: led=%h step=%b expected %h step=1", k, led, step, (k == 4) ? 24'h000003 : 24'h000006);
        end
      end
    end
  endtask

  task automatic test_rotate_right();
    en = 1'b1;
    do_load(24'h000001, 2'b10);
    for (int k = 1; k <= 8; k++) begin
      advance();
      total++;
      if (led !== m_led || step !== m_step) begin
        bad++;
        $display("[TB] FAIL rotr_model cycle %0d: led=%h step=%b expected led=%h step=%b", k, led, step, m_led, m_step);
      end
      if (k == 4 || k == 8) begin
        total++;
        if (step !== 1'b1 || led !== ((k == 4) ? 24'h800000 : 24'h400000)) begin
          bad++;
          $display("[TB] FAIL rotr_wrap cycle %0d: led=%h step=%b expected %h step=1", k, led, step, (k == 4) ? 24'h800000 : 24'h400000);
        end
      end
    end
  endtask

  task automatic test_blink_pause();
    en = 1'b1;
    do_load(24'hA5A5A5, 2'b11);
    for (int k = 1; k <= 6; k++) begin
      advance();
      if (k == 4) begin
        total++;
        if (step !== 1'b1 || led !== 24'h000000) begin
          bad++;
          $display("[TB] FAIL blink_off: led=%h step=%b expected led=000000 step=1", led, step);
        end
      end
    end
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      advance();
      total++;
      if (led !== 24'h000000 || step !== 1'b0) begin
        bad++;
        $display("[TB] FAIL blink_frozen cycle %0d: led=%h step=%b expected led=000000 step=0", k, led, step);
      end
    end
    en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      advance();
      total++;
      if (led !== m_led || step !== m_step) begin
        bad++;
        $display("[TB] FAIL blink_model cycle %0d: led=%h step=%b expected led=%h step=%b", k, led, step, m_led, m_step);
      end
      if (k == 2) begin
        total++;
        if (step !== 1'b1 || led !== 24'hA5A5A5) begin
          bad++;
          $display("[TB] FAIL blink_resume: led=%h step=%b expected led=a5a5a5 step=1", led, step);
        end
      end
    end
  endtask

  task automatic test_collision();
    en = 1'b1;
    do_load(24'h000001, 2'b01);
    advance();
    advance();
    advance();
    do_load(24'h00000F, 2'b01);
    total++;
    if (led !== 24'h00000F || step !== 1'b0) begin
      bad++;
      $display("[TB] FAIL collide_load: led=%h step=%b expected led=00000f step=0", led, step);
    end
    for (int k = 1; k <= 4; k++) begin
      advance();
      total++;
      if (step !== ((k == 4) ? 1'b1 : 1'b0) || led !== ((k == 4) ? 24'h00001E : 24'h00000F)) begin
        bad++;
        $display("[TB] FAIL collide_next cycle %0d: led=%h step=%b expected led=%h step=%b", k, led, step, (k == 4) ? 24'h00001E : 24'h00000F, (k == 4));
      end
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    do_load(24'h0000F0, 2'b01);
    advance();
    advance();
    rst = 1'b1;
    load = 1'b1;
    pattern = 24'h123456;
    advance();
    rst = 1'b0;
    load = 1'b0;
    total++;
    if (led !== 24'h000000 || step !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid: led=%h step=%b expected led=000000 step=0", led, step);
    end
    for (int k = 0; k < 12; k++) begin
      advance();
      total++;
      if (led !== 24'h000000 || step !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_mid_idle cycle %0d: led=%h step=%b expected led=000000 step=0", k, led, step);
      end
    end
  endtask

  task automatic test_saturated_patterns();
    logic [23:0] pats [3] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF};
    logic [1:0]  mods [3] = '{2'b01, 2'b10, 2'b00};
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_load(pats[i], mods[i]);
      for (int k = 1; k <= 4; k++) advance();
      total++;
      if (step !== 1'b1 || led !== pats[i]) begin
        bad++;
        $display("[TB] FAIL saturated_%0d: led=%h step=%b expected led=%h step=1", i, led, step, pats[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      load = ($urandom_range(0, 11) == 0);
      en = ($urandom_range(0, 4) != 0);
      mode = 2'($urandom);
      case ($urandom_range(0, 7))
        0: pattern = 24'h000000;
        1: pattern = 24'hFFFFFF;
        default: pattern = 24'($urandom);
      endcase
      advance();
      total++;
      if (led !== m_led || step !== m_step) begin
        bad++;
        $display("[TB] FAIL random cycle %0d: led=%h step=%b expected led=%h step=%b", k, led, step, m_led, m_step);
      end
    end
    rst = 1'b0;
    load = 1'b0;
  endtask

  initial begin
    m_run = 0; m_elapsed = 0; m_led = '0; m_pat = '0;
    m_mode = '0; m_on = 1; m_step = 0;
    test_reset();
    test_rotate_left();
    test_rotate_right();
    test_blink_pause();
    test_collision();
    test_reset_mid();
    test_saturated_patterns();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
